// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, mode/bit-order constants
// and the SCK half-period helper. Also intended for use by the SPI slave.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    FINISH
  } spi_state_t;

  // Bit 1 is CPOL, bit 0 is CPHA.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic       MSB_FIRST = 1'b1;

  // System-clock cycles per SCK phase; never less than one.
  function automatic int spi_half(input int clockHz, input int sckHz);
    int h;
    h = clockHz / (2 * sckHz);
    return (h < 1) ? 1 : h;
  endfunction

endpackage

// File: rtl/spi_clock_divider.sv
// SCK phase timer: counts HALF system-clock cycles per SCK phase and flags
// whether the phase boundary is a rising or falling SCK edge.
module spi_clock_divider #(
  parameter int HALF = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] r_count;
  logic          r_phase;
  logic          w_tick;

  assign w_tick = i_enable && (r_count == CW'(HALF - 1));
  assign o_rise = w_tick && !r_phase;
  assign o_fall = w_tick && r_phase;

  // The count restarts on every edge so SCK high and low phases are equal.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (i_enable) begin
      if (w_tick) begin
        r_count <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 byte initiator: byte handshake in, received bytes out as strobes,
// chip select held low across a burst until a byte flagged last completes.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int SPI_FREQUENCY   = 1000000,
  parameter int CS_GAP_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int HALF = spi_half(CLOCK_FREQUENCY, SPI_FREQUENCY);
  localparam int GW   = $clog2(CS_GAP_CYCLES + 1);

  spi_state_t r_state;
  logic [7:0] r_txShift;
  logic [7:0] r_rxShift;
  logic [7:0] r_rxData;
  logic       r_last;
  logic       r_rxValid;
  logic       r_spiClk;
  logic       r_spiCs;
  logic       r_mosi;
  logic [2:0] r_bitCnt;
  logic [GW-1:0] r_gapCnt;

  logic       w_accept;
  logic       w_divEnable;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_rxNext;
  logic [7:0] w_txNext;
  logic       w_firstBit;

  assign tx_ready = (r_state == IDLE) || (r_state == HOLD);
  assign busy     = (r_state != IDLE);
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign spi_clk  = r_spiClk;
  assign spi_cs   = r_spiCs;
  assign spi_mosi = r_mosi;

  assign w_accept   = tx_valid && tx_ready;
  assign w_rxNext   = MSB_FIRST ? {r_rxShift[6:0], spi_miso} : {spi_miso, r_rxShift[7:1]};
  assign w_txNext   = MSB_FIRST ? {r_txShift[6:0], 1'b0} : {1'b0, r_txShift[7:1]};
  assign w_firstBit = MSB_FIRST ? tx_data[7] : tx_data[0];

  // The divider stops during the strobe cycle that closes a byte.
  assign w_divEnable = (r_state == SETUP) || ((r_state == SHIFT) && !r_rxValid);

  spi_clock_divider #(
    .HALF(HALF)
  ) u_divider (
    .clock   (clock),
    .reset_n (reset_n),
    .i_enable(w_divEnable),
    .i_clear (!w_divEnable),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_txShift <= '0;
      r_rxShift <= '0;
      r_rxData  <= '0;
      r_last    <= 1'b0;
      r_rxValid <= 1'b0;
      r_spiClk  <= SPI_MODE0[1];
      r_spiCs   <= 1'b1;
      r_mosi    <= 1'b0;
      r_bitCnt  <= '0;
      r_gapCnt  <= '0;
    end else begin
      r_rxValid <= 1'b0;
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_txShift <= tx_data;
            r_last    <= tx_last;
            r_spiCs   <= 1'b0;
            r_mosi    <= w_firstBit;
            r_bitCnt  <= '0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_rise) begin
            r_spiClk  <= 1'b1;
            r_rxShift <= w_rxNext;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The cycle after the 8th falling edge decides burst continuation.
          if (r_rxValid) begin
            if (r_last) begin
              r_spiCs  <= 1'b1;
              r_mosi   <= 1'b0;
              r_gapCnt <= '0;
              r_state  <= FINISH;
            end else begin
              r_state <= HOLD;
            end
          end else if (w_rise) begin
            r_spiClk  <= 1'b1;
            r_rxShift <= w_rxNext;
          end else if (w_fall) begin
            r_spiClk <= 1'b0;
            if (r_bitCnt == 3'd7) begin
              r_rxData  <= r_rxShift;
              r_rxValid <= 1'b1;
            end else begin
              r_txShift <= w_txNext;
              r_mosi    <= MSB_FIRST ? w_txNext[7] : w_txNext[0];
            end
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        FINISH: begin
          if (r_gapCnt == GW'(CS_GAP_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: HALF=2 instance with a loopback/slave
// model and scoreboards, plus a HALF=1 instance for the clamped-divider case.
module tb_spi_master;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic       loopback;
  logic       slaveMiso;

  logic [7:0] f_tx_data;
  logic       f_tx_valid;
  logic       f_tx_last;
  logic       f_tx_ready;
  logic [7:0] f_rx_data;
  logic       f_rx_valid;
  logic       f_busy;
  logic       f_spi_clk;
  logic       f_spi_cs;
  logic       f_spi_mosi;
  logic       f_spi_miso;

  int testCount = 0;
  int failCount = 0;
  int cyc = 0;
  int lastAccept = 0;
  int csRises = 0;
  int holdSckHigh = 0;

  logic [7:0] rxExp[$];
  logic [7:0] txExp[$];
  logic [7:0] slaveQ[$];
  logic [7:0] fastExp[$];

  assign spi_miso   = loopback ? spi_mosi : slaveMiso;
  assign f_spi_miso = f_spi_mosi;

  spi_master #(
    .CLOCK_FREQUENCY(27000000),
    .SPI_FREQUENCY  (6750000),
    .CS_GAP_CYCLES  (4)
  ) uut (
    .clock(clock), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master #(
    .CLOCK_FREQUENCY(27000000),
    .SPI_FREQUENCY  (27000000),
    .CS_GAP_CYCLES  (4)
  ) uutFast (
    .clock(clock), .reset_n(reset_n),
    .tx_data(f_tx_data), .tx_valid(f_tx_valid), .tx_last(f_tx_last), .tx_ready(f_tx_ready),
    .rx_data(f_rx_data), .rx_valid(f_rx_valid), .busy(f_busy),
    .spi_clk(f_spi_clk), .spi_cs(f_spi_cs), .spi_mosi(f_spi_mosi), .spi_miso(f_spi_miso)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor plus mode-0 slave model, all sampled on the falling clock edge.
  logic       prevClk = 1'b0;
  logic       prevCs = 1'b1;
  logic       slaveActive = 1'b0;
  int         slaveBit = 0;
  logic [7:0] slaveByte = 8'h00;
  logic [7:0] monShift = 8'h00;
  int         monBits = 0;
  logic [7:0] expByte;

  always @(negedge clock) begin
    if (!reset_n) begin
      prevClk = 1'b0;
      prevCs = 1'b1;
      slaveActive = 1'b0;
      monBits = 0;
    end else begin
      if (rx_valid) begin
        testCount++;
        if (rxExp.size() == 0) begin
          failCount++;
          $display("[TB] FAIL rx_unexpected got rx_data=%h with no byte expected", rx_data);
        end else begin
          expByte = rxExp.pop_front();
          if (rx_data !== expByte) begin
            failCount++;
            $display("[TB] FAIL rx_data got %h expected %h", rx_data, expByte);
          end
        end
      end
      if (spi_cs) begin
        if (!prevCs) csRises++;
        monBits = 0;
        slaveActive = 1'b0;
      end else begin
        if (!slaveActive) begin
          slaveActive = 1'b1;
          slaveBit = 0;
          slaveByte = (slaveQ.size() != 0) ? slaveQ.pop_front() : 8'h00;
          slaveMiso = slaveByte[7];
        end
        if (spi_clk && !prevClk) begin
          monShift = {monShift[6:0], spi_mosi};
          monBits++;
          if (monBits == 8) begin
            monBits = 0;
            testCount++;
            if (txExp.size() == 0) begin
              failCount++;
              $display("[TB] FAIL mosi_unexpected got %h with no byte expected", monShift);
            end else begin
              expByte = txExp.pop_front();
              if (monShift !== expByte) begin
                failCount++;
                $display("[TB] FAIL mosi_byte got %h expected %h", monShift, expByte);
              end
            end
          end
          slaveBit++;
          if (slaveBit == 8) begin
            slaveBit = 0;
            slaveByte = (slaveQ.size() != 0) ? slaveQ.pop_front() : 8'h00;
          end
        end
        if (!spi_clk && prevClk) slaveMiso = slaveByte[7 - slaveBit];
        if (busy && tx_ready && spi_clk) holdSckHigh++;
      end
      prevClk = spi_clk;
      prevCs = spi_cs;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input bit keep);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      tx_data = d;
      tx_last = last;
      tx_valid = 1'b1;
      if (tx_ready) begin
        got = 1'b1;
        lastAccept = cyc;
      end
    end
    if (!got) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout got tx_ready=%b expected 1", tx_ready);
      tx_valid = 1'b0;
    end else begin
      @(negedge clock);
      if (!keep) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clock);
      if (!busy && tx_ready) done = 1'b1;
    end
    if (!done) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL idle_timeout got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_last = 1'b0;
    f_tx_valid = 1'b0;
    f_tx_data = 8'h00;
    f_tx_last = 1'b0;
    loopback = 1'b1;
    slaveMiso = 1'b0;
    repeat (3) @(negedge clock);
    testCount++;
    if ({spi_clk, spi_cs, spi_mosi, rx_valid, busy, tx_ready, rx_data} !== {6'b010001, 8'h00}) begin
      failCount++;
      $display("[TB] FAIL reset_values got clk/cs/mosi/rxv/busy/rdy/rx=%b/%b/%b/%b/%b/%b/%h expected 0/1/0/0/0/1/00",
               spi_clk, spi_cs, spi_mosi, rx_valid, busy, tx_ready, rx_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    testCount++;
    if ({spi_clk, spi_cs, busy, tx_ready} !== 4'b0101) begin
      failCount++;
      $display("[TB] FAIL post_reset_idle got clk/cs/busy/rdy=%b/%b/%b/%b expected 0/1/0/1",
               spi_clk, spi_cs, busy, tx_ready);
    end
    testCount++;
    if ({f_spi_cs, f_busy, f_tx_ready} !== 3'b101) begin
      failCount++;
      $display("[TB] FAIL fast_reset got cs/busy/rdy=%b/%b/%b expected 1/0/1", f_spi_cs, f_busy, f_tx_ready);
    end
  endtask

  task automatic test_single_byte();
    int rel;
    int csHighAt;
    int rvAt;
    int rvCount;
    int firstRise;
    int readyAt;
    logic csAt1;
    csHighAt = -1; rvAt = -1; rvCount = 0; firstRise = -1; readyAt = -1;
    loopback = 1'b1;
    rxExp.push_back(8'hA5);
    txExp.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    csAt1 = spi_cs;
    for (int k = 0; k < 40; k++) begin
      rel = cyc - lastAccept;
      if (spi_cs && csHighAt < 0) csHighAt = rel;
      if (rx_valid) begin
        rvCount++;
        rvAt = rel;
      end
      if (spi_clk && firstRise < 0) firstRise = rel;
      if (tx_ready && readyAt < 0) readyAt = rel;
      @(negedge clock);
    end
    testCount++;
    if (csAt1 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cs_low_at_1 got %b expected 0", csAt1);
    end
    testCount++;
    if (firstRise != 3) begin
      failCount++;
      $display("[TB] FAIL first_sck_rise got cycle %0d expected 3", firstRise);
    end
    testCount++;
    if (rvAt != 33 || rvCount != 1) begin
      failCount++;
      $display("[TB] FAIL rx_valid_timing got cycle %0d count %0d expected cycle 33 count 1", rvAt, rvCount);
    end
    testCount++;
    if (csHighAt != 34) begin
      failCount++;
      $display("[TB] FAIL cs_release got cycle %0d expected 34", csHighAt);
    end
    testCount++;
    if (readyAt != 38) begin
      failCount++;
      $display("[TB] FAIL cs_gap_ready got cycle %0d expected 38", readyAt);
    end
  endtask

  task automatic test_burst();
    int r0;
    int h0;
    int a1;
    int a2;
    loopback = 1'b0;
    slaveQ.push_back(8'h3C); slaveQ.push_back(8'hC3); slaveQ.push_back(8'h00);
    rxExp.push_back(8'h3C);  rxExp.push_back(8'hC3);  rxExp.push_back(8'h00);
    txExp.push_back(8'h01);  txExp.push_back(8'h80);  txExp.push_back(8'hFF);
    r0 = csRises;
    h0 = holdSckHigh;
    send_byte(8'h01, 1'b0, 1'b1);
    a1 = lastAccept;
    send_byte(8'h80, 1'b0, 1'b1);
    a2 = lastAccept;
    send_byte(8'hFF, 1'b1, 1'b0);
    wait_idle();
    testCount++;
    if (a2 - a1 != 34) begin
      failCount++;
      $display("[TB] FAIL burst_period got %0d cycles expected 34", a2 - a1);
    end
    testCount++;
    if (csRises - r0 != 1) begin
      failCount++;
      $display("[TB] FAIL burst_cs_rises got %0d expected 1", csRises - r0);
    end
    testCount++;
    if (holdSckHigh - h0 != 0) begin
      failCount++;
      $display("[TB] FAIL hold_sck got %0d high cycles expected 0", holdSckHigh - h0);
    end
    loopback = 1'b1;
  endtask

  task automatic test_hold_stall();
    bit inHold;
    int badCs;
    int badClk;
    int badBusy;
    int badReady;
    inHold = 1'b0; badCs = 0; badClk = 0; badBusy = 0; badReady = 0;
    loopback = 1'b1;
    rxExp.push_back(8'h12);
    txExp.push_back(8'h12);
    send_byte(8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !inHold; i++) begin
      @(negedge clock);
      if (busy && tx_ready) inHold = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      if (spi_cs !== 1'b0) badCs++;
      if (spi_clk !== 1'b0) badClk++;
      if (busy !== 1'b1) badBusy++;
      if (tx_ready !== 1'b1) badReady++;
      @(negedge clock);
    end
    testCount++;
    if (badCs != 0) begin
      failCount++;
      $display("[TB] FAIL hold_cs got %0d cycles high expected 0", badCs);
    end
    testCount++;
    if (badClk != 0) begin
      failCount++;
      $display("[TB] FAIL hold_clk got %0d cycles high expected 0", badClk);
    end
    testCount++;
    if (badBusy != 0) begin
      failCount++;
      $display("[TB] FAIL hold_busy got %0d cycles low expected 0", badBusy);
    end
    testCount++;
    if (badReady != 0) begin
      failCount++;
      $display("[TB] FAIL hold_ready got %0d cycles low expected 0", badReady);
    end
    rxExp.push_back(8'h55);
    txExp.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_ignore_during_shift();
    bit inShift;
    bit seen;
    int readyHigh;
    inShift = 1'b0; seen = 1'b0; readyHigh = 0;
    loopback = 1'b1;
    rxExp.push_back(8'hC6);
    txExp.push_back(8'hC6);
    send_byte(8'hC6, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !inShift; i++) begin
      if (spi_clk) inShift = 1'b1;
      else @(negedge clock);
    end
    tx_data = 8'h39;
    tx_last = 1'b0;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (tx_ready) readyHigh++;
      if (rx_valid) seen = 1'b1;
    end
    tx_valid = 1'b0;
    testCount++;
    if (!seen) begin
      failCount++;
      $display("[TB] FAIL shift_complete got no rx_valid expected one");
    end
    testCount++;
    if (readyHigh != 0) begin
      failCount++;
      $display("[TB] FAIL ready_in_shift got %0d cycles high expected 0", readyHigh);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_transfer();
    loopback = 1'b1;
    send_byte(8'hE7, 1'b1, 1'b0);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    testCount++;
    if ({spi_cs, spi_clk, spi_mosi, busy, rx_valid} !== 5'b10000) begin
      failCount++;
      $display("[TB] FAIL abort_outputs got cs/clk/mosi/busy/rxv=%b/%b/%b/%b/%b expected 1/0/0/0/0",
               spi_cs, spi_clk, spi_mosi, busy, rx_valid);
    end
    testCount++;
    if (rx_data !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL abort_rx_data got %h expected 00", rx_data);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rxExp.push_back(8'h3C);
    txExp.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0);
    wait_idle();
  endtask

  task automatic test_fast_clock();
    int acc;
    bit got;
    logic [7:0] e;
    got = 1'b0;
    fastExp.push_back(8'h96);
    @(negedge clock);
    f_tx_data = 8'h96;
    f_tx_last = 1'b1;
    f_tx_valid = 1'b1;
    acc = cyc;
    testCount++;
    if (f_tx_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fast_ready got %b expected 1", f_tx_ready);
    end
    @(negedge clock);
    f_tx_valid = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (f_rx_valid) begin
        got = 1'b1;
        e = fastExp.pop_front();
        testCount++;
        if (cyc - acc != 17) begin
          failCount++;
          $display("[TB] FAIL fast_rx_cycle got %0d expected 17", cyc - acc);
        end
        testCount++;
        if (f_rx_data !== e) begin
          failCount++;
          $display("[TB] FAIL fast_rx_data got %h expected %h", f_rx_data, e);
        end
        @(negedge clock);
        testCount++;
        if (f_rx_valid !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL fast_rx_strobe got %b one cycle later expected 0", f_rx_valid);
        end
      end else begin
        @(negedge clock);
      end
    end
    if (!got) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL fast_rx_timeout got no rx_valid expected one");
    end
    repeat (10) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_hold_stall();
    test_ignore_during_shift();
    test_reset_mid_transfer();
    test_fast_clock();
    repeat (5) @(negedge clock);
    testCount++;
    if (rxExp.size() != 0) begin
      failCount++;
      $display("[TB] FAIL rx_leftover got %0d bytes outstanding expected 0", rxExp.size());
    end
    testCount++;
    if (txExp.size() != 0) begin
      failCount++;
      $display("[TB] FAIL mosi_leftover got %0d bytes outstanding expected 0", txExp.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0), MSB-first byte initiator on the 27 MHz system clock; the controller side for the existing SPI slave, so the FPGA can drive external SPI peripherals or loop back into its own slave for self-test. A byte handshake on the fabric side feeds bytes in. Received bytes come out as single-cycle strobes. Multi-byte bursts keep chip select low until a byte is flagged last.

## Interface
- CLOCK_FREQUENCY, 27000000, system clock in Hz
- SPI_FREQUENCY, 1000000, target SCK in Hz; HALF = max(1, CLOCK_FREQUENCY/(2*SPI_FREQUENCY)) clock cycles per SCK phase
- CS_GAP_CYCLES, 4, minimum clock cycles CS stays high after a burst ends (≥1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tx_data  in  8  byte to send, captured on accept
- tx_valid  in  1  tx_data valid
- tx_last  in  1  captured with tx_data; 1 = release CS after this byte
- tx_ready  out  1  block can accept a byte
- rx_data  out  8  last received byte, held until next
- rx_valid  out  1  one-cycle strobe, rx_data new
- busy  out  1  state ≠ IDLE
- spi_clk  out  1  SCK
- spi_cs  out  1  chip select, active low
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

## Operation
- Reset values: spi_clk 0, spi_cs 1, spi_mosi 0, rx_data 0, rx_valid 0, busy 0, tx_ready 1 (state IDLE). Reset mid-transfer aborts at once; no partial rx_valid.
- Accept = tx_valid & tx_ready. tx_ready = state ∈ {IDLE, HOLD}; tx_valid ignored otherwise.
- States:
  - IDLE: on accept, latch shift register ← tx_data and last ← tx_last; spi_cs ← 0; spi_mosi ← tx_data[7] → SETUP.
  - SETUP: hold for HALF cycles (CS-to-first-edge setup) → SHIFT.
  - SHIFT: 8 SCK periods. Each rising edge samples spi_miso into rx shift LSB. Each falling edge except the 8th drives the next bit on spi_mosi. After the 8th falling edge: rx_data ← assembled byte, rx_valid pulses. Then → FINISH if last, else → HOLD.
  - HOLD: CS low, SCK low, waits indefinitely. On accept, latch the new byte and flag, spi_mosi ← bit7 → SETUP.
  - FINISH: spi_cs ← 1, spi_mosi ← 0, count CS_GAP_CYCLES → IDLE.
- spi_miso sampled directly (no synchronizer). The slave changes MISO on the falling edge, so it is stable ≥HALF cycles before the rising-edge sample.
- rx_valid has no backpressure; a consumer must take the byte in that cycle.

## Timing
- Accept at cycle 0: spi_cs low at cycle 1. First spi_clk rise at 1+HALF. Rise k (k=0..7) at 1+HALF+2k·HALF; fall k at 1+2(k+1)·HALF.
- rx_valid at cycle 1+16·HALF, exactly one cycle. Same cycle, state leaves SHIFT. tx_ready high the next cycle if HOLD.
- FINISH: spi_cs high from 2+16·HALF for CS_GAP_CYCLES cycles. Earliest next accept at 2+16·HALF+CS_GAP_CYCLES.
- Burst with tx_valid held high: next accept the cycle HOLD is entered. Back-to-back byte period = 2+16·HALF cycles.
- HALF counter wraps to 0 on each SCK edge. SPI_FREQUENCY > CLOCK_FREQUENCY/2 clamps HALF to 1.
- Bit counter 3 bits, wraps after bit 7 exactly at the 8th falling edge.

## Structure
- Shared package spi_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, FINISH) and SPI_MODE0/MSB_FIRST constants, also usable by the slave.
- One sub-module, spi_clock_divider: HALF-cycle tick counter with enable and synchronous clear, emitting rise/fall ticks. Everything else stays in spi_master.

## Test plan
- Single byte, HALF=2, tx_data=0xA5, tx_last=1, spi_miso looped to spi_mosi → MOSI bits 1,0,1,0,0,1,0,1. rx_valid only at cycle 33 with rx_data=0xA5. spi_cs low cycles 1–33, high ≥4 cycles after.
- Burst 0x01,0x80,0xFF (last on 0xFF), slave model returns 0x3C,0xC3,0x00 → three rx_valid pulses with those values. spi_cs never rises between bytes; SCK low in HOLD.
- HOLD stall: after first byte, tx_valid low 100 cycles → spi_cs stays 0, spi_clk stays 0, busy 1, tx_ready 1. Then byte 0x55 with tx_last=1 completes normally.
- tx_valid asserted during SHIFT with different data → ignored; transmitted byte unchanged; tx_ready 0 throughout.
- reset_n low at cycle 10 of a transfer → same-cycle spi_cs 1, spi_clk 0, spi_mosi 0, busy 0. No rx_valid; next byte 0x3C transfers correctly.
- SPI_FREQUENCY=27000000 (HALF clamps to 1) with 0x96 loopback → rx_data=0x96 at cycle 17.
